// File: rtl/conv_mem_responder.sv
`default_nettype none
// ============================================================================
// Module   : conv_mem_responder
// Purpose  : Memory-side responder for the image convolution engine. Holds
//            the input image and every layer result in one flat word array.
//            It loads the image from a host valid/ready stream, runs the
//            ready/busy start handshake with the engine, serves the engine's
//            image-ROM and layer-memory ports, and gives the host a
//            combinational read-back port for every region.
// Ports    : clk, reset                    - clock, async active-high reset
//            ld_valid/ld_data/ld_ready     - host image stream (raster order)
//            start/done                    - host start pulse / finish pulse
//            ready/busy                    - engine start handshake
//            iaddr/idata                   - engine image read (combinational)
//            cwr/caddr_wr/cdata_wr         - engine layer write
//            crd/caddr_rd/cdata_rd/csel    - engine layer read, layer select
//            hrd_sel/hrd_addr/hrd_data     - host read-back (sel 0 = image)
//            wr_cnt                        - accepted engine writes this run
//            err                           - sticky bad-write flag
// Options  : MEM_WR_CHECK_EN - when defined, err latches on any write with a
//            bad select/address or any write outside the run phase. When not
//            defined, err is tied to 0 (bad writes are still dropped).
// Revision : 1.0 - initial release
// ============================================================================
module conv_mem_responder #(
  parameter int DATA_W    = 20,
  parameter int ADDR_W    = 12,
  parameter int IMG_WORDS = 4096
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              ld_valid,
  input  logic [DATA_W-1:0] ld_data,
  output logic              ld_ready,
  input  logic              start,
  output logic              done,
  output logic              ready,
  input  logic              busy,
  input  logic [ADDR_W-1:0] iaddr,
  output logic [DATA_W-1:0] idata,
  input  logic              cwr,
  input  logic [ADDR_W-1:0] caddr_wr,
  input  logic [DATA_W-1:0] cdata_wr,
  input  logic              crd,
  input  logic [ADDR_W-1:0] caddr_rd,
  output logic [DATA_W-1:0] cdata_rd,
  input  logic [2:0]        csel,
  input  logic [2:0]        hrd_sel,
  input  logic [ADDR_W-1:0] hrd_addr,
  output logic [DATA_W-1:0] hrd_data,
  output logic [14:0]       wr_cnt,
  output logic              err
);

  localparam int c_FLAT_W    = 15;
  localparam int c_MEM_WORDS = 20480;
  localparam int c_CNT_W     = (IMG_WORDS > 1) ? $clog2(IMG_WORDS) : 1;
  localparam logic [c_CNT_W-1:0] c_CNT_LAST   = c_CNT_W'(IMG_WORDS - 1);
  localparam logic [14:0]        c_WR_CNT_MAX = 15'h7FFF;

  typedef enum logic [2:0] {
    S_LOAD  = 3'd0,
    S_ARMED = 3'd1,
    S_START = 3'd2,
    S_RUN   = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t              r_state;
  logic                r_ld_ready;
  logic                r_ready;
  logic                r_done;
  logic [c_CNT_W-1:0]  r_cnt;
  logic [14:0]         r_wr_cnt;
  logic [DATA_W-1:0]   r_mem [c_MEM_WORDS];

  // Region decode: returns {valid, flat address}. Select 0 is the image and
  // is only legal for the host read-back port (img_ok=1).
  function automatic logic [c_FLAT_W:0] f_decode(input logic [2:0]        sel,
                                                 input logic [ADDR_W-1:0] addr,
                                                 input logic              img_ok);
    int unsigned base;
    int unsigned size;
    int unsigned a;
    base = 0;
    size = 0;
    a    = 32'(addr);
    case (sel)
      3'd0: if (img_ok) size = 4096;
      3'd1: begin base = 4096;  size = 4096; end
      3'd2: begin base = 8192;  size = 4096; end
      3'd3: begin base = 12288; size = 1024; end
      3'd4: begin base = 13312; size = 1024; end
      3'd5: begin base = 14336; size = 2048; end
      default: ;
    endcase
    f_decode = {(size != 0) && (a < size), c_FLAT_W'(base + a)};
  endfunction

  logic [c_FLAT_W:0]   w_wr_dec;
  logic [c_FLAT_W:0]   w_rd_dec;
  logic [c_FLAT_W:0]   w_hrd_dec;
  logic                w_wr_ok;
  logic                w_ld_fire;
  logic                w_eng_wr;

  assign w_wr_dec  = f_decode(csel, caddr_wr, 1'b0);
  assign w_rd_dec  = f_decode(csel, caddr_rd, 1'b0);
  assign w_hrd_dec = f_decode(hrd_sel, hrd_addr, 1'b1);
  assign w_wr_ok   = w_wr_dec[c_FLAT_W];

  assign w_ld_fire = (r_state == S_LOAD) && r_ld_ready && ld_valid;
  assign w_eng_wr  = (r_state == S_RUN) && cwr && w_wr_ok;

  // Storage is not reset; contents survive reset and the next image load.
  // Loader and engine writes are exclusive by state.
  always_ff @(posedge clk) begin
    if (w_ld_fire) begin
      r_mem[c_FLAT_W'(r_cnt)] <= ld_data;
    end else if (w_eng_wr) begin
      r_mem[w_wr_dec[c_FLAT_W-1:0]] <= cdata_wr;
    end
  end

  // Zero-latency reads: a same-cycle write lands at the edge, so a read of
  // that word in the same cycle sees the old value.
  assign idata    = r_mem[c_FLAT_W'(iaddr)];
  assign cdata_rd = (crd && w_rd_dec[c_FLAT_W]) ? r_mem[w_rd_dec[c_FLAT_W-1:0]] : '0;
  assign hrd_data = w_hrd_dec[c_FLAT_W] ? r_mem[w_hrd_dec[c_FLAT_W-1:0]] : '0;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= S_LOAD;
      r_ld_ready <= 1'b0;
      r_ready    <= 1'b0;
      r_done     <= 1'b0;
      r_cnt      <= '0;
      r_wr_cnt   <= '0;
    end else begin
      if (w_eng_wr && (r_wr_cnt != c_WR_CNT_MAX)) begin
        r_wr_cnt <= r_wr_cnt + 15'd1;
      end
      case (r_state)
        S_LOAD: begin
          r_ld_ready <= 1'b1;
          if (w_ld_fire) begin
            r_cnt <= r_cnt + 1'b1;
            if (r_cnt == c_CNT_LAST) begin
              r_state    <= S_ARMED;
              r_ld_ready <= 1'b0;
              r_cnt      <= '0;
            end
          end
        end
        S_ARMED: begin
          r_ld_ready <= 1'b0;
          if (start) begin
            r_state  <= S_START;
            r_ready  <= 1'b1;
            r_wr_cnt <= '0;
          end
        end
        S_START: begin
          if (busy) begin
            r_state <= S_RUN;
            r_ready <= 1'b0;
          end
        end
        S_RUN: begin
          if (!busy) begin
            r_state <= S_DONE;
            r_done  <= 1'b1;
          end
        end
        S_DONE: begin
          r_done     <= 1'b0;
          r_state    <= S_LOAD;
          r_cnt      <= '0;
          r_ld_ready <= 1'b1;
        end
        default: begin
          r_state    <= S_LOAD;
          r_ld_ready <= 1'b0;
          r_ready    <= 1'b0;
          r_done     <= 1'b0;
          r_cnt      <= '0;
        end
      endcase
    end
  end

  assign ld_ready = r_ld_ready;
  assign ready    = r_ready;
  assign done     = r_done;
  assign wr_cnt   = r_wr_cnt;

`ifdef MEM_WR_CHECK_EN
  logic r_err;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_err <= 1'b0;
    end else if (cwr && (!w_wr_ok || (r_state != S_RUN))) begin
      r_err <= 1'b1;
    end
  end

  assign err = r_err;
`else
  assign err = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_conv_mem_responder.sv
`default_nettype none
// ============================================================================
// Module   : tb_conv_mem_responder
// Purpose  : Directed self-checking bench for conv_mem_responder: image load,
//            start handshake, layer writes/reads, invalid writes, same-cycle
//            read/write ordering, done pulse and mid-run reset.
// Revision : 1.0 - initial release
// ============================================================================
module tb_conv_mem_responder;

  logic        clk;
  logic        reset;
  logic        ld_valid;
  logic [19:0] ld_data;
  logic        ld_ready;
  logic        start;
  logic        done;
  logic        ready;
  logic        busy;
  logic [11:0] iaddr;
  logic [19:0] idata;
  logic        cwr;
  logic [11:0] caddr_wr;
  logic [19:0] cdata_wr;
  logic        crd;
  logic [11:0] caddr_rd;
  logic [19:0] cdata_rd;
  logic [2:0]  csel;
  logic [2:0]  hrd_sel;
  logic [11:0] hrd_addr;
  logic [19:0] hrd_data;
  logic [14:0] wr_cnt;
  logic        err;

  int n_total = 0;
  int n_pass  = 0;

  conv_mem_responder dut (
    .clk      (clk),
    .reset    (reset),
    .ld_valid (ld_valid),
    .ld_data  (ld_data),
    .ld_ready (ld_ready),
    .start    (start),
    .done     (done),
    .ready    (ready),
    .busy     (busy),
    .iaddr    (iaddr),
    .idata    (idata),
    .cwr      (cwr),
    .caddr_wr (caddr_wr),
    .cdata_wr (cdata_wr),
    .crd      (crd),
    .caddr_rd (caddr_rd),
    .cdata_rd (cdata_rd),
    .csel     (csel),
    .hrd_sel  (hrd_sel),
    .hrd_addr (hrd_addr),
    .hrd_data (hrd_data),
    .wr_cnt   (wr_cnt),
    .err      (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic hrd_chk(input string tag, input logic [2:0] sel, input logic [11:0] addr,
                         input logic [19:0] exp);
    hrd_sel  = sel;
    hrd_addr = addr;
    #1;
    check(tag, 32'(hrd_data), 32'(exp));
  endtask

  // mode 0: value = index, valid idles every third cycle; mode 1: value = 4095-index, no idles
  task automatic load_image(input int mode);
    int  i;
    int  k;
    logic rdy;
    i = 0;
    k = 0;
    while (i < 4096 && k < 20000) begin
      @(negedge clk);
      ld_valid = (mode == 1) ? 1'b1 : ((k % 3) != 2);
      ld_data  = (mode == 1) ? 20'(4095 - i) : 20'(i);
      rdy      = ld_ready;
      @(posedge clk);
      if (ld_valid && rdy) i++;
      k++;
    end
    check("load_count", 32'(i), 32'd4096);
    @(negedge clk);
    ld_valid = 1'b0;
  endtask

  // Start pulse, busy raised after ready has been up for 4 sampled cycles
  task automatic run_start(input string tag);
    int rc;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    rc = 0;
    for (int c = 1; c <= 6; c++) begin
      if (ready) rc++;
      if (c == 4) busy = 1'b1;
      @(negedge clk);
    end
    check({tag, "_ready_cycles"}, 32'(rc), 32'd4);
    check({tag, "_ready_low"}, 32'(ready), 32'd0);
  endtask

  task automatic wr(input logic [2:0] sel, input logic [11:0] addr, input logic [19:0] data);
    csel     = sel;
    caddr_wr = addr;
    cdata_wr = data;
    cwr      = 1'b1;
    @(negedge clk);
    cwr      = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  initial begin
    logic exp_err;
`ifdef MEM_WR_CHECK_EN
    exp_err = 1'b1;
`else
    exp_err = 1'b0;
`endif
    reset = 1'b1; ld_valid = 1'b0; ld_data = '0; start = 1'b0; busy = 1'b0;
    iaddr = '0; cwr = 1'b0; caddr_wr = '0; cdata_wr = '0; crd = 1'b0;
    caddr_rd = '0; csel = '0; hrd_sel = '0; hrd_addr = '0;

    repeat (2) @(negedge clk);
    check("rst_ld_ready", 32'(ld_ready), 32'd0);
    check("rst_ready",    32'(ready),    32'd0);
    check("rst_done",     32'(done),     32'd0);
    check("rst_wr_cnt",   32'(wr_cnt),   32'd0);
    check("rst_err",      32'(err),      32'd0);
    reset = 1'b0;
    @(negedge clk);
    check("ld_ready_up", 32'(ld_ready), 32'd1);

    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("start_ignored_load", 32'(ready), 32'd0);

    // ---- image load ----
    load_image(0);
    check("ld_ready_armed", 32'(ld_ready), 32'd0);
    iaddr = 12'hABC; #1;
    check("idata_abc", 32'(idata), 32'h00ABC);
    iaddr = 12'hFFF; #1;
    check("idata_fff", 32'(idata), 32'h00FFF);
    ld_valid = 1'b1; ld_data = 20'hFFFFF;
    @(negedge clk);
    ld_valid = 1'b0;
    hrd_chk("ld_ignored_armed", 3'd0, 12'd0, 20'd0);
    check("ld_ready_still_low", 32'(ld_ready), 32'd0);

    // ---- run 1 ----
    run_start("run1");
    check("wr_cnt_start", 32'(wr_cnt), 32'd0);

    wr(3'd1, 12'd5, 20'h12345);
    crd = 1'b1; csel = 3'd1; caddr_rd = 12'd5; #1;
    check("crd_l1_5", 32'(cdata_rd), 32'h12345);
    crd = 1'b0; #1;
    check("crd_low_zero", 32'(cdata_rd), 32'd0);
    hrd_chk("hrd_l1_5", 3'd1, 12'd5, 20'h12345);
    check("wr_cnt_1", 32'(wr_cnt), 32'd1);
    check("err_clean", 32'(err), 32'd0);

    wr(3'd4, 12'd0, 20'h0AAAA);
    wr(3'd3, 12'd1024, 20'h55555);
    wr(3'd0, 12'd5, 20'h77777);
    hrd_chk("l4_intact", 3'd4, 12'd0, 20'h0AAAA);
    hrd_chk("img5_intact", 3'd0, 12'd5, 20'd5);
    check("wr_cnt_2", 32'(wr_cnt), 32'd2);
    check("err_bad_wr", 32'(err), 32'(exp_err));
    crd = 1'b1; csel = 3'd3; caddr_rd = 12'd1024; #1;
    check("crd_oor_zero", 32'(cdata_rd), 32'd0);
    csel = 3'd6; caddr_rd = 12'd0; #1;
    check("crd_sel6_zero", 32'(cdata_rd), 32'd0);
    crd = 1'b0;

    wr(3'd5, 12'd2047, 20'h11111);
    csel = 3'd5; caddr_wr = 12'd2047; cdata_wr = 20'h22222; cwr = 1'b1;
    crd = 1'b1; caddr_rd = 12'd2047; #1;
    check("rw_same_old", 32'(cdata_rd), 32'h11111);
    @(negedge clk);
    cwr = 1'b0; #1;
    check("rw_same_new", 32'(cdata_rd), 32'h22222);
    crd = 1'b0;
    check("wr_cnt_4", 32'(wr_cnt), 32'd4);

    busy = 1'b0;
    @(negedge clk);
    check("done_pulse", 32'(done), 32'd1);
    @(negedge clk);
    check("done_single", 32'(done), 32'd0);
    check("ld_ready_after_done", 32'(ld_ready), 32'd1);

    // ---- run 2, then reset mid-run ----
    load_image(1);
    run_start("run2");
    check("wr_cnt_cleared", 32'(wr_cnt), 32'd0);
    hrd_chk("reload_img0", 3'd0, 12'd0, 20'd4095);
    wr(3'd2, 12'd4095, 20'h3CAFE);
    check("wr_cnt_run2", 32'(wr_cnt), 32'd1);

    #2 reset = 1'b1;
    #1;
    check("midrst_ready",    32'(ready),    32'd0);
    check("midrst_done",     32'(done),     32'd0);
    check("midrst_ld_ready", 32'(ld_ready), 32'd0);
    check("midrst_wr_cnt",   32'(wr_cnt),   32'd0);
    check("midrst_err",      32'(err),      32'd0);
    busy = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    hrd_chk("keep_l2_4095", 3'd2, 12'd4095, 20'h3CAFE);
    hrd_chk("keep_l1_5",    3'd1, 12'd5,    20'h12345);
    hrd_chk("keep_img0",    3'd0, 12'd0,    20'd4095);
    @(negedge clk);
    check("ld_ready_reload", 32'(ld_ready), 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/conv_mem_responder.md
Name: conv_mem_responder

Overview:
- Memory-side responder for the image convolution engine. Serves the engine's image-ROM port (iaddr/idata) and its layer-memory ports (cwr/caddr_wr/cdata_wr, crd/caddr_rd/cdata_rd, csel).
- Runs the ready/busy start handshake and tells the host when the engine has finished.
- Takes the input image from a host valid/ready stream.
- Gives the host a combinational read-back port for every layer.

Parameters:
- DATA_W, 20, word width of pixels and layer data.
- ADDR_W, 12, engine address width.
- IMG_WORDS, 4096, number of pixels loaded before the block can arm.

Ports:
- clk  input  1  clock
- reset  input  1  asynchronous active-high reset
- ld_valid  input  1  host pixel valid
- ld_data  input  DATA_W  host pixel, written in raster order
- ld_ready  output  1  block accepts a pixel
- start  input  1  host start pulse, honoured only in S_ARMED
- done  output  1  one-cycle pulse when the engine finishes
- ready  output  1  engine start request
- busy  input  1  engine busy
- iaddr  input  ADDR_W  image read address
- idata  output  DATA_W  image data, combinational from iaddr
- cwr  input  1  layer write enable
- caddr_wr  input  ADDR_W  layer write address
- cdata_wr  input  DATA_W  layer write data
- crd  input  1  layer read enable
- caddr_rd  input  ADDR_W  layer read address
- cdata_rd  output  DATA_W  layer read data, combinational
- csel  input  3  layer select
- hrd_sel  input  3  host read-back layer select; 0 = image
- hrd_addr  input  ADDR_W  host read-back address
- hrd_data  output  DATA_W  host read-back data, combinational
- wr_cnt  output  15  number of accepted engine writes in the current run
- err  output  1  sticky error flag; see Optional Feature

Behaviour:
- Reset is asynchronous and active-high. It sets state=S_LOAD, ld_ready=0, ready=0, done=0, pixel counter=0, wr_cnt=0, err=0. Memory contents are not cleared.
- Storage is a single flat array of 20480 words:
  - image at base 0, 4096 words
  - csel=1 (L0 conv k0) at base 4096, 4096 words
  - csel=2 (L0 conv k1) at base 8192, 4096 words
  - csel=3 (L1 pool k0) at base 12288, 1024 words
  - csel=4 (L1 pool k1) at base 13312, 1024 words
  - csel=5 (flatten) at base 14336, 2048 words
- Address decode: flat address = base + addr. A csel of 0, 6 or 7 is invalid. An address at or beyond the region size is invalid.
- Reads (idata, cdata_rd, hrd_data) are purely combinational, so data is valid in the same cycle as the address.
  - The engine samples data the cycle after it registers the address; no read latency is allowed.
- cdata_rd returns 0 if crd=0 or the access is invalid. idata always returns image[iaddr].
- Writes take effect at the clock edge. They are accepted only in S_RUN with cwr=1 and a valid csel/address; otherwise the write is dropped.
- A read and a write to the same word in the same cycle returns the old data.
- wr_cnt increments on each accepted write, saturates at 32767, and clears on the S_ARMED->S_START transition.
- FSM:
  - S_LOAD: ld_ready=1. Each ld_valid&&ld_ready writes image[cnt] and increments cnt. When pixel IMG_WORDS-1 is accepted, go to S_ARMED and drop ld_ready the next cycle.
  - S_ARMED: ld_ready=0. On start=1, go to S_START.
  - S_START: ready=1 is held until busy=1 is sampled, then go to S_RUN with ready=0.
  - S_RUN: wait for busy=0, then go to S_DONE.
  - S_DONE: done=1 for exactly one cycle, then go to S_LOAD with cnt=0.
- start outside S_ARMED is ignored. ld_valid outside S_LOAD is ignored.
- Reset mid-run returns to S_LOAD. Memory keeps its contents and the image must be reloaded.

Optional Feature:
- Macro: MEM_WR_CHECK_EN.
- Defined: err is set, and stays set until reset, when either of these occurs:
  - cwr=1 with invalid csel or out-of-range address in any state
  - cwr=1 outside S_RUN
- Not defined: err is tied to 0. Invalid writes are still dropped.

Test Plan:
- Stream 4096 pixels (value = index) with ld_valid idle every third cycle -> ld_ready=0 after the 4096th pixel, state S_ARMED; iaddr=0xABC -> idata=0x00ABC in the same cycle.
- Pulse start, then raise busy 3 cycles later -> ready=1 for 4 cycles, then 0; wr_cnt=0.
- In S_RUN: cwr, csel=1, addr=5, data=0x12345; next cycle crd, csel=1, addr=5 -> cdata_rd=0x12345 same cycle; hrd_sel=1, hrd_addr=5 -> 0x12345; wr_cnt=1.
- csel=3, addr=1024 write and csel=0 write -> memory unchanged, wr_cnt unchanged, err=1 only with MEM_WR_CHECK_EN; crd at csel=3, addr=1024 -> 0.
- Write and read csel=5, addr=2047 in the same cycle -> old data returned; the new value is visible the next cycle.
- Drop busy -> done=1 for one cycle the following cycle, ld_ready=1 after; assert reset mid-S_RUN -> ready=0, done=0, state S_LOAD, written data preserved.
